// File: rtl/flopen_write_arbiter_if.sv
// Bus between the write requesters and the shared-register arbiter.
// Handshake: req[i] is a level "valid" held by requester i together with
// stable wdata slice i; gnt[i] is a one-cycle "ready/accept" pulse. A write is
// transferred on the cycle gnt[i]=1. The requester keeps req high to ask for
// another write, or drops it once it has seen its grant.
interface flopen_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   reg_en;
  logic [WIDTH-1:0]       reg_d;
  logic                   busy;
  logic                   dbg_state;
  logic [PTR_W-1:0]       dbg_ptr;

  // Requester side
  modport master (
    output req, wdata,
    input  gnt, reg_en, reg_d, busy, dbg_state, dbg_ptr
  );

  // Arbiter side
  modport slave (
    input  req, wdata,
    output gnt, reg_en, reg_d, busy, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/flopen_write_arbiter.sv
// Round-robin write arbiter driving the E/D ports of one shared enabled
// register. One requester wins per cycle; its data and the enable are
// registered so the shared register updates on the following edge.
module flopen_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  flopen_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt_q;
  logic             reg_en_q;
  logic [WIDTH-1:0] reg_d_q;
  logic [PTR_W-1:0] ptr;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [PTR_W-1:0] winner;
  int               idx;

  // Mask the requester granted last cycle, then search from ptr with wrap
  always_comb begin
    eligible = bus.req & ~((state == WRITE) ? gnt_q : '0);
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // FSM and registered outputs; reset wins over any request
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt_q    <= '0;
      reg_en_q <= 1'b0;
      reg_d_q  <= '0;
      ptr      <= '0;
    end else if (found) begin
      state    <= WRITE;
      gnt_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
      reg_en_q <= 1'b1;
      reg_d_q  <= bus.wdata[int'(winner)*WIDTH +: WIDTH];
      ptr      <= (int'(winner) == N_REQ-1) ? '0 : winner + 1'b1;
    end else begin
      // No winner: drop the enable, keep reg_d and ptr
      state    <= IDLE;
      gnt_q    <= '0;
      reg_en_q <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.reg_en    = reg_en_q;
  assign bus.reg_d     = reg_d_q;
  assign bus.busy      = (state == WRITE);
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;
endmodule

// File: tb/tb_flopen_write_arbiter.sv
// Directed bench for flopen_write_arbiter (N_REQ=4, WIDTH=8) with a model of
// the downstream enabled register fed from reg_en/reg_d.
module tb_flopen_write_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] q;

  flopen_write_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  flopen_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and the shared Flopenr stand-in
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (bus.reg_en) q <= bus.reg_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic en,
                            input logic [7:0] d);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, ".en"}, 32'(bus.reg_en), 32'(en));
    check({tag, ".d"}, 32'(bus.reg_d), 32'(d));
    check({tag, ".busy"}, 32'(bus.busy), 32'(en));
  endtask

  logic [3:0] seq [5];

  initial begin
    checks = 0;
    errors = 0;
    // Requester data: idx0=B0 idx1=C2 idx2=A5 idx3=D3
    bus.wdata = {8'hD3, 8'hA5, 8'hC2, 8'hB0};
    bus.req   = 4'b1111;
    reset     = 1'b1;

    // 1. reset holds everything at zero despite requests
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out("rst", 4'b0000, 1'b0, 8'h00);
      check("rst.state", 32'(bus.dbg_state), 32'd0);
      check("rst.ptr", 32'(bus.dbg_ptr), 32'd0);
    end

    // 2. single request from requester 2
    reset   = 1'b0;
    bus.req = 4'b0100;
    tick();
    expect_out("single", 4'b0100, 1'b1, 8'hA5);
    check("single.ptr", 32'(bus.dbg_ptr), 32'd3);
    bus.req = 4'b0000;
    tick();
    expect_out("single_off", 4'b0000, 1'b0, 8'hA5);
    check("single.q", 32'(q), 32'hA5);
    tick();
    check("single.qhold", 32'(q), 32'hA5);
    check("single.ptrhold", 32'(bus.dbg_ptr), 32'd3);

    // 3. full rotation from ptr=0, including wrap
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    bus.req = 4'b1111;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rot.gnt", 32'(bus.gnt), 32'(seq[i]));
      check("rot.en", 32'(bus.reg_en), 32'd1);
    end
    check("rot.d", 32'(bus.reg_d), 32'hB0);
    check("rot.ptr", 32'(bus.dbg_ptr), 32'd1);

    // 4. grant to 2 (ptr=3), then req=0101 -> 0001 then 0100
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    bus.req = 4'b0100;
    tick();
    expect_out("mask.g2", 4'b0100, 1'b1, 8'hA5);
    bus.req = 4'b0101;
    tick();
    expect_out("mask.g0", 4'b0001, 1'b1, 8'hB0);
    check("mask.ptr1", 32'(bus.dbg_ptr), 32'd1);
    tick();
    expect_out("mask.g2b", 4'b0100, 1'b1, 8'hA5);
    check("mask.ptr3", 32'(bus.dbg_ptr), 32'd3);

    // 5. lone requester 1 alternates because of the one-edge mask
    bus.req = 4'b0010;
    tick();
    expect_out("alt.0", 4'b0010, 1'b1, 8'hC2);
    tick();
    expect_out("alt.1", 4'b0000, 1'b0, 8'hC2);
    tick();
    expect_out("alt.2", 4'b0010, 1'b1, 8'hC2);
    tick();
    expect_out("alt.3", 4'b0000, 1'b0, 8'hC2);
    check("alt.ptr", 32'(bus.dbg_ptr), 32'd2);

    // 6. reset during WRITE drops the write; restart grants index 0
    bus.req = 4'b1111;
    tick();
    expect_out("rw.pre", 4'b0100, 1'b1, 8'hA5);
    reset = 1'b1;
    tick();
    expect_out("rw.rst", 4'b0000, 1'b0, 8'h00);
    check("rw.ptr", 32'(bus.dbg_ptr), 32'd0);
    check("rw.state", 32'(bus.dbg_state), 32'd0);
    reset = 1'b0;
    tick();
    expect_out("rw.first", 4'b0001, 1'b1, 8'hB0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
